alu_issue_ctrl: RTL and testbench

//  Multi-cycle issue/writeback controller that drives the 16-bit ALU (func ADD/SUB/MUL/SLT).

---
 rtl/alu_issue_ctrl.sv | 131 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the 16-bit ALU: accepts one instruction at a time,
// reads operands from an 8-entry register file, drives the ALU and writes its result back.
module alu_issue_ctrl #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [15:0]           instr,
  output logic [1:0]            alu_func,
  output logic [DATA_W-1:0]     alu_srcdata_1,
  output logic [DATA_W-1:0]     alu_srcdata_2,
  input  logic [DATA_W-1:0]     alu_result,
  output logic                  done,
  output logic [REG_ADDR_W-1:0] done_rd,
  output logic [DATA_W-1:0]     done_data,
  input  logic [REG_ADDR_W-1:0] dbg_rd_addr,
  output logic [DATA_W-1:0]     dbg_rd_data
);

  localparam int NREG = 2 ** REG_ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  state_t                state_q, state_d;
  logic                  live_q;
  logic [15:0]           instr_q, instr_d;
  logic [1:0]            func_q, func_d;
  logic [DATA_W-1:0]     src1_q, src1_d;
  logic [DATA_W-1:0]     src2_q, src2_d;
  logic [DATA_W-1:0]     result_q, result_d;
  logic [DATA_W-1:0]     rf_q [NREG];

  logic                  is_li;
  logic [REG_ADDR_W-1:0] rd_w, rs1_w, rs2_w;
  logic [DATA_W-1:0]     rs1_data, rs2_data, imm_sext;
  logic                  accept;
  logic                  wb_en;

  function automatic logic [DATA_W-1:0] rf_read(input logic [REG_ADDR_W-1:0] a);
    // R0 reads as zero regardless of storage contents.
    if (a == '0) rf_read = '0;
    else         rf_read = rf_q[a];
  endfunction

  assign is_li    = instr_q[15];
  assign rd_w     = is_li ? instr_q[14:12] : instr_q[12:10];
  assign rs1_w    = instr_q[9:7];
  assign rs2_w    = instr_q[6:4];
  assign imm_sext = {{(DATA_W-12){instr_q[11]}}, instr_q[11:0]};
  assign rs1_data = rf_read(rs1_w);
  assign rs2_data = rf_read(rs2_w);

  // live_q holds ready low until the first clock edge after reset release.
  assign instr_ready   = live_q && (state_q == S_IDLE);
  assign accept        = instr_valid && instr_ready;
  assign done          = (state_q == S_WB);
  assign done_rd       = done ? rd_w : '0;
  assign done_data     = done ? result_q : '0;
  assign wb_en         = done && (rd_w != '0);
  assign alu_func      = func_q;
  assign alu_srcdata_1 = src1_q;
  assign alu_srcdata_2 = src2_q;
  assign dbg_rd_data   = rf_read(dbg_rd_addr);

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    func_d   = func_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          instr_d = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_li) begin
          result_d = imm_sext;
          state_d  = S_WB;
        end else begin
          func_d  = instr_q[14:13];
          src1_d  = rs1_data;
          src2_d  = rs2_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = alu_result;
        state_d  = S_WB;
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      live_q   <= 1'b0;
      instr_q  <= '0;
      func_q   <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      result_q <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      live_q   <= 1'b1;
      instr_q  <= instr_d;
      func_q   <= func_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      result_q <= result_d;
      if (wb_en) rf_q[rd_w] <= result_q;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU attached to its ALU ports.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [1:0]  alu_func;
  logic [15:0] alu_srcdata_1, alu_srcdata_2;
  logic [15:0] alu_result;
  logic        done;
  logic [2:0]  done_rd;
  logic [15:0] done_data;
  logic [2:0]  dbg_rd_addr = '0;
  logic [15:0] dbg_rd_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_acc = 0;
  int last_gap = 0;

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] data;
    int          acc;
    int          lat;
    bit          is_alu;
    logic [1:0]  f;
    logic [15:0] s1;
    logic [15:0] s2;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  alu_issue_ctrl #(.DATA_W(16), .REG_ADDR_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .alu_func     (alu_func),
    .alu_srcdata_1(alu_srcdata_1),
    .alu_srcdata_2(alu_srcdata_2),
    .alu_result   (alu_result),
    .done         (done),
    .done_rd      (done_rd),
    .done_data    (done_data),
    .dbg_rd_addr  (dbg_rd_addr),
    .dbg_rd_data  (dbg_rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    alu_result = '0;
    case (alu_func)
      2'b00: alu_result = alu_srcdata_1 + alu_srcdata_2;
      2'b01: alu_result = alu_srcdata_1 - alu_srcdata_2;
      2'b10: alu_result = alu_srcdata_1 * alu_srcdata_2;
      default: alu_result = (alu_srcdata_1 < alu_srcdata_2) ? 16'h0001 : 16'h0000;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got rd=%0d data=%0h expected no done", done_rd, done_data);
      end else begin
        mon_e = sb.pop_front();
        chk("done_rd", done_rd, mon_e.rd);
        chk("done_data", done_data, mon_e.data);
        chk("done_latency", cyc - mon_e.acc, mon_e.lat);
        if (mon_e.is_alu) begin
          chk("alu_func", alu_func, mon_e.f);
          chk("alu_src1", alu_srcdata_1, mon_e.s1);
          chk("alu_src2", alu_srcdata_2, mon_e.s2);
        end
      end
    end
  end

  function automatic logic [15:0] mk_alu(input logic [1:0] f, input logic [2:0] rd,
                                         input logic [2:0] rs1, input logic [2:0] rs2);
    mk_alu = {1'b0, f, rd, rs1, rs2, 4'b0000};
  endfunction

  function automatic logic [15:0] mk_li(input logic [2:0] rd, input logic [11:0] imm);
    mk_li = {1'b1, rd, imm};
  endfunction

  task automatic push_exp(input logic [15:0] w, input logic [15:0] d, input bit is_alu,
                          input logic [15:0] s1, input logic [15:0] s2);
    exp_t e;
    e.rd     = is_alu ? w[12:10] : w[14:12];
    e.data   = d;
    e.acc    = cyc + 1;
    e.lat    = is_alu ? 2 : 1;
    e.is_alu = is_alu;
    e.f      = w[14:13];
    e.s1     = s1;
    e.s2     = s2;
    sb.push_back(e);
    last_gap = cyc + 1 - last_acc;
    last_acc = cyc + 1;
  endtask

  task automatic issue(input logic [15:0] w, input logic [15:0] d, input bit is_alu,
                       input logic [15:0] s1, input logic [15:0] s2);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b1;
    instr = w;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (instr_ready) got = 1'b1;
    end
    if (!got) chk("ready_timeout", 0, 1);
    else push_exp(w, d, is_alu, s1, s2);
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic dbg(input logic [2:0] a, input logic [15:0] exp);
    dbg_rd_addr = a;
    #1;
    chk($sformatf("dbg_r%0d", a), dbg_rd_data, exp);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_done_rd"}, done_rd, 0);
    chk({tag, "_done_data"}, done_data, 0);
    chk({tag, "_alu_func"}, alu_func, 0);
    chk({tag, "_src1"}, alu_srcdata_1, 0);
    chk({tag, "_src2"}, alu_srcdata_2, 0);
    chk({tag, "_ready"}, instr_ready, 0);
  endtask

  initial begin
    int cnt;
    bit got;

    // Reset state
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    for (int a = 0; a < 8; a++) dbg(3'(a), 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", instr_ready, 1);

    // LI with sign extension, back-to-back to observe the accept spacing
    issue(mk_li(3'd1, 12'h7FF), 16'h07FF, 1'b0, '0, '0);
    issue(mk_li(3'd2, 12'hFFE), 16'hFFFE, 1'b0, '0, '0);
    chk("li_accept_gap", last_gap, 3);
    drain();
    dbg(3'd1, 16'h07FF);
    dbg(3'd2, 16'hFFFE);

    // ADD/SUB wrap, back-to-back
    issue(mk_alu(2'b00, 3'd3, 3'd1, 3'd2), 16'h07FD, 1'b1, 16'h07FF, 16'hFFFE);
    issue(mk_alu(2'b01, 3'd4, 3'd2, 3'd1), 16'hF7FF, 1'b1, 16'hFFFE, 16'h07FF);
    chk("alu_accept_gap", last_gap, 4);
    drain();
    dbg(3'd3, 16'h07FD);
    dbg(3'd4, 16'hF7FF);

    // MUL low half, SLT unsigned both directions
    issue(mk_alu(2'b10, 3'd5, 3'd2, 3'd2), 16'h0004, 1'b1, 16'hFFFE, 16'hFFFE);
    drain();
    dbg(3'd5, 16'h0004);
    issue(mk_alu(2'b11, 3'd6, 3'd1, 3'd2), 16'h0001, 1'b1, 16'h07FF, 16'hFFFE);
    drain();
    dbg(3'd6, 16'h0001);
    issue(mk_alu(2'b11, 3'd6, 3'd2, 3'd1), 16'h0000, 1'b1, 16'hFFFE, 16'h07FF);
    drain();
    dbg(3'd6, 16'h0000);

    // rd equals a source: operands are pre-write values
    issue(mk_alu(2'b00, 3'd5, 3'd5, 3'd5), 16'h0008, 1'b1, 16'h0004, 16'h0004);
    drain();
    dbg(3'd5, 16'h0008);

    // Write to R0 with instr_valid held through busy cycles
    @(posedge clk); #1;
    instr_valid = 1'b1;
    instr = mk_alu(2'b00, 3'd0, 3'd1, 3'd1);
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        push_exp(instr, 16'h0FFE, 1'b1, 16'h07FF, 16'h07FF);
        cnt++;
      end
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("held_valid_accepts", cnt, 3);
    drain();
    dbg(3'd0, 16'h0000);

    // Reset during EXEC aborts the instruction
    @(posedge clk); #1;
    instr_valid = 1'b1;
    instr = mk_alu(2'b00, 3'd7, 3'd1, 3'd1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (instr_ready) got = 1'b1;
    end
    chk("abort_accept_seen", got, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    @(negedge clk);
    chk("midrst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dbg(3'd7, 16'h0000);
    dbg(3'd1, 16'h0000);
    repeat (4) @(negedge clk);
    issue(mk_li(3'd7, 12'h123), 16'h0123, 1'b0, '0, '0);
    drain();
    dbg(3'd7, 16'h0123);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
